// File: rtl/checkpoint_monitor.sv
// Checkpoint sequencer: watches a status bus for an ordered list of signatures and
// reports a registered pass/fail verdict with the failing stage and cause.
module checkpoint_monitor #(
  parameter  int WIDTH     = 16,
  parameter  int DEPTH     = 4,
  parameter  int TIMEOUT_W = 16,
  parameter  int HOLD      = 2,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int SW        = $clog2(DEPTH + 1)
) (
  input  logic                 clock,
  input  logic                 resetb,
  input  logic                 cfg_we,
  input  logic [AW-1:0]        cfg_addr,
  input  logic [WIDTH-1:0]     cfg_data,
  input  logic [SW-1:0]        cfg_len,
  input  logic [TIMEOUT_W-1:0] cfg_timeout,
  input  logic                 arm,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     watch,
  output logic                 busy,
  output logic                 pass,
  output logic                 fail,
  output logic [1:0]           fail_code,
  output logic [SW-1:0]        stage,
  output logic [TIMEOUT_W-1:0] stage_cycles
);

  localparam int HW  = $clog2(HOLD + 1);
  localparam int TW1 = TIMEOUT_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PASS, ST_FAIL} state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     sig_q [DEPTH];
  logic [SW-1:0]        len_q, stage_q, stage_d, len_clamp;
  logic [TIMEOUT_W-1:0] timeout_q, stage_cycles_q, stage_cycles_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic                 busy_q, pass_q, fail_q;
  logic [1:0]           fail_code_q;
  logic [WIDTH-1:0]     cur_sig;
  logic                 hit, accept, order_err, budget_out;
  logic [TW1-1:0]       cycles_plus1;

  // Signature table; slots are only writable between runs.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
        sig_q[gi] <= '0;
      end else if (cfg_we && !busy_q && (cfg_addr == AW'(gi))) begin
        sig_q[gi] <= cfg_data;
      end
    end
  end

  always_comb begin
    cur_sig   = '0;
    order_err = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      if (stage_q == SW'(j)) cur_sig = sig_q[j];
      if ((SW'(j) > stage_q) && (SW'(j) < len_q) && (watch == sig_q[j])) order_err = 1'b1;
    end
  end

  assign hit            = (watch == cur_sig);
  assign hold_d         = hold_q + HW'(1);
  assign accept         = hit && (hold_d == HW'(HOLD));
  assign stage_d        = stage_q + SW'(1);
  assign cycles_plus1   = {1'b0, stage_cycles_q} + TW1'(1);
  assign stage_cycles_d = (&stage_cycles_q) ? stage_cycles_q : cycles_plus1[TIMEOUT_W-1:0];
  assign budget_out     = (timeout_q != '0) && (cycles_plus1 >= {1'b0, timeout_q});
  assign len_clamp      = (cfg_len > SW'(DEPTH)) ? SW'(DEPTH) : cfg_len;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q        <= ST_IDLE;
      len_q          <= '0;
      timeout_q      <= '0;
      stage_q        <= '0;
      stage_cycles_q <= '0;
      hold_q         <= '0;
      busy_q         <= 1'b0;
      pass_q         <= 1'b0;
      fail_q         <= 1'b0;
      fail_code_q    <= 2'b00;
    end else if (abort) begin
      state_q        <= ST_IDLE;
      len_q          <= '0;
      timeout_q      <= '0;
      stage_q        <= '0;
      stage_cycles_q <= '0;
      hold_q         <= '0;
      busy_q         <= 1'b0;
      pass_q         <= 1'b0;
      fail_q         <= 1'b0;
      fail_code_q    <= 2'b00;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (accept) begin
            stage_q        <= stage_d;
            stage_cycles_q <= '0;
            hold_q         <= '0;
            if (stage_d == len_q) begin
              state_q <= ST_PASS;
              busy_q  <= 1'b0;
              pass_q  <= 1'b1;
            end
          end else begin
            hold_q         <= hit ? hold_d : '0;
            stage_cycles_q <= stage_cycles_d;
            // The budget covers every non-accepting edge, including partial matches.
            if (!hit && order_err) begin
              state_q     <= ST_FAIL;
              busy_q      <= 1'b0;
              fail_q      <= 1'b1;
              fail_code_q <= 2'b10;
            end else if (budget_out) begin
              state_q     <= ST_FAIL;
              busy_q      <= 1'b0;
              fail_q      <= 1'b1;
              fail_code_q <= 2'b01;
            end
          end
        end
        default: begin
          if (arm) begin
            len_q          <= len_clamp;
            timeout_q      <= cfg_timeout;
            stage_q        <= '0;
            stage_cycles_q <= '0;
            hold_q         <= '0;
            fail_q         <= 1'b0;
            fail_code_q    <= 2'b00;
            if (len_clamp == '0) begin
              state_q <= ST_PASS;
              busy_q  <= 1'b0;
              pass_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
              pass_q  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign pass         = pass_q;
  assign fail         = fail_q;
  assign fail_code    = fail_code_q;
  assign stage        = stage_q;
  assign stage_cycles = stage_cycles_q;

endmodule

// File: tb/tb_checkpoint_monitor.sv
// Directed bench for checkpoint_monitor: a per-edge model of the sequencing rules is
// compared against every output each cycle, plus hand-computed literal checkpoints.
module tb_checkpoint_monitor;

  localparam int WIDTH     = 16;
  localparam int DEPTH     = 4;
  localparam int TIMEOUT_W = 16;
  localparam int HOLD      = 2;
  localparam int AW        = 2;
  localparam int SW        = 3;

  logic                 clock = 1'b0;
  logic                 resetb;
  logic                 cfg_we;
  logic [AW-1:0]        cfg_addr;
  logic [WIDTH-1:0]     cfg_data;
  logic [SW-1:0]        cfg_len;
  logic [TIMEOUT_W-1:0] cfg_timeout;
  logic                 arm;
  logic                 abort;
  logic [WIDTH-1:0]     watch;
  logic                 busy;
  logic                 pass;
  logic                 fail;
  logic [1:0]           fail_code;
  logic [SW-1:0]        stage;
  logic [TIMEOUT_W-1:0] stage_cycles;

  checkpoint_monitor #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT_W(TIMEOUT_W), .HOLD(HOLD)
  ) dut (
    .clock(clock), .resetb(resetb), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_len(cfg_len), .cfg_timeout(cfg_timeout),
    .arm(arm), .abort(abort), .watch(watch), .busy(busy), .pass(pass),
    .fail(fail), .fail_code(fail_code), .stage(stage), .stage_cycles(stage_cycles)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model state, expressed directly in terms of the observable verdict.
  logic [WIDTH-1:0] tbl [DEPTH];
  int m_busy, m_pass, m_fail, m_code, m_stage, m_cycles, m_len, m_tmo, m_streak;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    m_busy = 0; m_pass = 0; m_fail = 0; m_code = 0;
    m_stage = 0; m_cycles = 0; m_len = 0; m_tmo = 0; m_streak = 0;
  endtask

  task automatic model_reset();
    model_clear();
    for (int i = 0; i < DEPTH; i++) tbl[i] = '0;
  endtask

  task automatic model_step();
    int was_busy;
    int later;
    was_busy = m_busy;
    later    = 0;
    if (abort) begin
      model_clear();
      return;
    end
    if (cfg_we && !was_busy && int'(cfg_addr) < DEPTH) tbl[cfg_addr] = cfg_data;
    if (!was_busy) begin
      if (arm) begin
        m_len = (int'(cfg_len) > DEPTH) ? DEPTH : int'(cfg_len);
        m_tmo = int'(cfg_timeout);
        m_pass = 0; m_fail = 0; m_code = 0; m_stage = 0; m_cycles = 0; m_streak = 0;
        if (m_len == 0) m_pass = 1;
        else m_busy = 1;
      end
      return;
    end
    for (int j = m_stage + 1; j < m_len; j++) if (watch == tbl[j]) later = 1;
    if (watch == tbl[m_stage]) begin
      m_streak++;
      if (m_streak == HOLD) begin
        m_stage++;
        m_cycles = 0;
        m_streak = 0;
        if (m_stage == m_len) begin
          m_busy = 0;
          m_pass = 1;
        end
        return;
      end
    end else begin
      m_streak = 0;
      if (later) begin
        m_fail = 1; m_code = 2; m_busy = 0;
      end
    end
    if (m_busy && m_tmo != 0 && m_cycles + 1 >= m_tmo) begin
      m_fail = 1; m_code = 1; m_busy = 0;
    end
    if (m_cycles < 65535) m_cycles++;
  endtask

  task automatic compare_model();
    check("busy", int'(busy), m_busy);
    check("pass", int'(pass), m_pass);
    check("fail", int'(fail), m_fail);
    check("fail_code", int'(fail_code), m_code);
    check("stage", int'(stage), m_stage);
    check("stage_cycles", int'(stage_cycles), m_cycles);
  endtask

  task automatic tick();
    @(posedge clock);
    cyc++;
    if (!resetb) model_reset();
    else model_step();
    @(negedge clock);
    compare_model();
  endtask

  task automatic write_sig(input int addr, input int data);
    cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_data = WIDTH'(data);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic arm_run(input int len, input int tmo);
    cfg_len = SW'(len); cfg_timeout = TIMEOUT_W'(tmo); arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic drive(input int value, input int edges);
    watch = WIDTH'(value);
    repeat (edges) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "bench did not finish");
  end

  initial begin
    resetb = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_len = '0;
    cfg_timeout = '0; arm = 1'b0; abort = 1'b0; watch = '0;
    model_reset();
    tick(); tick();
    check("rst_busy", int'(busy), 0);
    check("rst_stage", int'(stage), 0);
    resetb = 1'b1;
    tick();
    $display("txn reset done");

    write_sig(0, 'hAB60);
    write_sig(1, 'h1337);
    arm_run(2, 100);
    check("arm_busy", int'(busy), 1);
    drive('hAB60, 2);
    check("basic_stage1", int'(stage), 1);
    drive('h1337, 1);
    check("basic_not_yet", int'(pass), 0);
    drive('h1337, 1);
    check("basic_pass", int'(pass), 1);
    check("basic_stage2", int'(stage), 2);
    check("basic_busy", int'(busy), 0);
    $display("txn basic_pass done");

    arm_run(2, 100);
    drive('hAB60, 1);
    drive('h0000, 1);
    drive('hAB60, 1);
    check("glitch_hold", int'(stage), 0);
    drive('hAB60, 1);
    check("glitch_adv", int'(stage), 1);
    drive('h1337, 2);
    check("glitch_pass", int'(pass), 1);
    $display("txn glitch_filter done");

    watch = '0;
    arm_run(2, 10);
    drive(0, 9);
    check("tmo_not_yet", int'(fail), 0);
    drive(0, 1);
    check("tmo_fail", int'(fail), 1);
    check("tmo_code", int'(fail_code), 1);
    check("tmo_stage", int'(stage), 0);
    check("tmo_cycles", int'(stage_cycles), 10);
    arm_run(2, 10);
    drive(0, 8);
    drive('hAB60, 2);
    check("tmo_edge_stage", int'(stage), 1);
    check("tmo_edge_nofail", int'(fail), 0);
    drive('h1337, 2);
    check("tmo_edge_pass", int'(pass), 1);
    $display("txn timeout done");

    write_sig(2, 'h0042);
    arm_run(3, 100);
    drive('h1337, 1);
    check("ooo_fail", int'(fail), 1);
    check("ooo_code", int'(fail_code), 2);
    check("ooo_stage", int'(stage), 0);
    watch = 'h0042;
    arm_run(2, 100);
    drive('h0042, 3);
    check("ooo_outside_len", int'(fail), 0);
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_idle", int'(busy), 0);
    $display("txn out_of_order done");

    watch = '0;
    arm_run(2, 5);
    drive(0, 2);
    cfg_timeout = TIMEOUT_W'(100); arm = 1'b1; tick(); arm = 1'b0;
    check("rearm_busy", int'(busy), 1);
    drive(0, 2);
    check("rearm_ignored", int'(fail_code), 1);
    cfg_len = SW'(2); abort = 1'b1; arm = 1'b1; tick(); abort = 1'b0; arm = 1'b0;
    check("abort_arm_busy", int'(busy), 0);
    check("abort_arm_fail", int'(fail), 0);
    tick();
    $display("txn controls done");

    arm_run(2, 0);
    write_sig(0, 'h5555);
    drive('hAB60, 2);
    check("we_busy_ignored", int'(stage), 1);
    drive(0, 30);
    check("tmo0_nofail", int'(fail), 0);
    check("tmo0_busy", int'(busy), 1);
    abort = 1'b1; tick(); abort = 1'b0;
    arm_run(0, 0);
    check("len0_pass", int'(pass), 1);
    check("len0_busy", int'(busy), 0);
    write_sig(3, 'h0F0F);
    arm_run(7, 200);
    drive('hAB60, 2);
    drive('h1337, 2);
    drive('h0042, 2);
    drive('h0F0F, 2);
    check("clamp_pass", int'(pass), 1);
    check("clamp_stage", int'(stage), 4);
    $display("txn len_and_table done");

    watch = '0;
    arm_run(2, 100);
    drive('hAB60, 2);
    check("mid_stage1", int'(stage), 1);
    watch = 'h1337;
    #2 resetb = 1'b0;
    model_reset();
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_stage", int'(stage), 0);
    compare_model();
    tick();
    resetb = 1'b1;
    watch = '0;
    arm_run(2, 100);
    drive(0, 4);
    check("zero_tbl_pass", int'(pass), 1);
    check("zero_tbl_stage", int'(stage), 2);
    $display("txn reset_mid_run done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
